// File: rtl/pipe_ctrl.sv
// Y86 5-stage pipeline control: load-use stalls, mispredict squash, ret bubbles,
// exception halt, plus saturating cycle/stall/bubble counters.
module pipe_ctrl #(
    parameter int CNT_W   = 32,
    parameter int RET_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       d_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [7:0]       e_icode,
    input  logic [3:0]       e_dstM,
    input  logic             e_cnd,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       w_stat,
    output logic             f_stall,
    output logic             d_stall,
    output logic             d_bubble,
    output logic             e_bubble,
    output logic             m_bubble,
    output logic             w_stall,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    localparam int RW = $clog2(RET_LAT + 1);

    typedef enum logic [1:0] {S_RUN, S_RET_WAIT, S_HALTED} state_t;

    state_t          r_state, w_next;
    logic [RW-1:0]   r_ret_cnt, w_ret_cnt_nxt;
    logic            w_lu, w_mp, w_rt, w_exc;

    assign w_lu  = (e_icode == 8'h05 || e_icode == 8'h0B) && (e_dstM != 4'hF) &&
                   (e_dstM == d_srcA || e_dstM == d_srcB);
    assign w_mp  = (e_icode == 8'h07) && !e_cnd;
    assign w_rt  = (d_icode == 8'h09);
    assign w_exc = (m_stat != 2'd0) || (w_stat != 2'd0);

    always_comb begin
        f_stall       = 1'b0;
        d_stall       = 1'b0;
        d_bubble      = 1'b0;
        e_bubble      = 1'b0;
        m_bubble      = 1'b0;
        w_stall       = 1'b0;
        halted        = 1'b0;
        w_next        = r_state;
        w_ret_cnt_nxt = r_ret_cnt;
        case (r_state)
            S_RUN: begin
                if (w_lu) begin
                    f_stall  = 1'b1;
                    d_stall  = 1'b1;
                    e_bubble = 1'b1;
                end else if (w_mp) begin
                    // a ret in D here is on the wrong path and is squashed
                    d_bubble = 1'b1;
                    e_bubble = 1'b1;
                end else if (w_rt) begin
                    f_stall       = 1'b1;
                    d_bubble      = 1'b1;
                    w_ret_cnt_nxt = RW'(RET_LAT - 1);
                    w_next        = (RET_LAT > 1) ? S_RET_WAIT : S_RUN;
                end
            end
            S_RET_WAIT: begin
                f_stall       = 1'b1;
                d_bubble      = 1'b1;
                w_ret_cnt_nxt = r_ret_cnt - RW'(1);
                if (r_ret_cnt <= RW'(1))
                    w_next = S_RUN;
            end
            S_HALTED: begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_bubble = 1'b1;
                m_bubble = 1'b1;
                w_stall  = 1'b1;
                halted   = 1'b1;
            end
            default: w_next = S_RUN;
        endcase
        // exceptions stop younger instructions from touching CC/memory
        if (r_state != S_HALTED && w_exc) begin
            m_bubble = 1'b1;
            if (w_stat != 2'd0) begin
                w_stall = 1'b1;
                w_next  = S_HALTED;
            end
        end
        if (!rst) begin
            f_stall  = 1'b0;
            d_stall  = 1'b0;
            d_bubble = 1'b0;
            e_bubble = 1'b0;
            m_bubble = 1'b0;
            w_stall  = 1'b0;
            halted   = 1'b0;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_RUN;
            r_ret_cnt  <= '0;
            cyc_cnt    <= '0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_ret_cnt <= w_ret_cnt_nxt;
            if (r_state != S_HALTED) begin
                cyc_cnt <= sat_inc(cyc_cnt);
                if (f_stall)
                    stall_cnt <= sat_inc(stall_cnt);
                if (d_bubble || e_bubble || m_bubble)
                    bubble_cnt <= sat_inc(bubble_cnt);
            end
        end
    end
endmodule
